series_job_sequencer: RTL and testbench

- Upstream feeder and downstream collector for the ROM-based series engine controller.
- Accepts operand words on a valid/ready stream and buffers them in a small FIFO.
- Drives each operand, plus a one-cycle start pulse, to the engine; detects completion from the engine's ready level and captures the engine result.
- Presents results on an output valid/ready stream, with a watchdog flag for a hung engine.

---
 rtl/series_job_sequencer_pkg.sv | 16 +
 rtl/series_job_sequencer_sync_fifo.sv | 48 ++++
 rtl/series_job_sequencer.sv | 135 +++++++++++++
 tb/tb_series_job_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/series_job_sequencer_pkg.sv
// seq_pkg: shared state encoding and default widths
// for the series job sequencer and its queue stages.
package seq_pkg;

  localparam int W_DEF  = 16;
  localparam int RW_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAITBUSY = 3'd2,
    S_WAITDONE = 3'd3,
    S_CAPTURE  = 3'd4
  } state_t;

endpackage

// File: rtl/series_job_sequencer_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers,
// first-word-fall-through read port.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  // pointer update; extra MSB tells full from empty
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // storage write, no reset needed on the array
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/series_job_sequencer.sv
// series_job_sequencer: feeds operands to the series engine,
// collects results, and flags a hung engine.
module series_job_sequencer
  import seq_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int RW    = RW_DEF,
  parameter int DEPTH = 4,
  parameter int TMO   = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          eng_start,
  output logic [W-1:0]  eng_x,
  input  logic          eng_ready,
  input  logic [RW-1:0] eng_r,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  input  logic          out_ready,
  output logic          timeout,
  output logic          busy
);

  localparam int CW = $clog2(TMO + 1);

  state_t         state;
  state_t         state_n;
  logic           fifo_full;
  logic           fifo_empty;
  logic [W-1:0]   fifo_dout;
  logic           pop;
  logic           cap;
  logic           wd_clr;
  logic           wd_inc;
  logic           wd_hit;
  logic           tmo_fire;
  logic [CW-1:0]  wd;

  assign in_ready = !fifo_full;
  assign wd_hit   = (wd == CW'(TMO - 1));
  assign busy     = (state != S_IDLE) || !fifo_empty;

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // next state and per-state strobes
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    cap       = 1'b0;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    tmo_fire  = 1'b0;
    eng_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty && eng_ready && !out_valid) begin
          state_n = S_START;
          pop     = 1'b1;
          wd_clr  = 1'b1;
        end
      end
      S_START: begin
        eng_start = 1'b1;
        state_n   = S_WAITBUSY;
      end
      S_WAITBUSY: begin
        if (wd_hit) begin
          tmo_fire = 1'b1;
          state_n  = S_IDLE;
        end else begin
          wd_inc = 1'b1;
          if (!eng_ready) state_n = S_WAITDONE;
        end
      end
      S_WAITDONE: begin
        if (wd_hit) begin
          tmo_fire = 1'b1;
          state_n  = S_IDLE;
        end else begin
          wd_inc = 1'b1;
          if (eng_ready) state_n = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cap     = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // operand latch, watchdog, result slot and sticky timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eng_x     <= '0;
      wd        <= '0;
      timeout   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (pop) eng_x <= fifo_dout;
      if (wd_clr)      wd <= '0;
      else if (wd_inc) wd <= wd + 1'b1;
      if (tmo_fire) timeout <= 1'b1;
      if (cap) begin
        out_data  <= eng_r;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_series_job_sequencer.sv
// tb_series_job_sequencer: engine model, operand scoreboard
// and directed plus random job traffic.
module tb_series_job_sequencer;

  localparam int W     = 16;
  localparam int RW    = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          eng_start;
  logic [W-1:0]  eng_x;
  logic          eng_ready;
  logic [RW-1:0] eng_r = '0;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          timeout;
  logic          busy;

  always #5 clock = ~clock;

  series_job_sequencer #(
    .W(W), .RW(RW), .DEPTH(DEPTH), .TMO(TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_ready (eng_ready),
    .eng_r     (eng_r),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .timeout   (timeout),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // test knobs
  int          lat = 4;
  bit          hang = 0;
  bit          eng_block = 0;
  bit          auto_ready = 1;
  bit          man_ready = 0;
  bit          fixed_en = 0;
  logic [15:0] fixed_r = '0;

  // model state
  int          cyc = 0;
  bit          e_busy = 0;
  int          e_cnt = 0;
  logic [15:0] e_x = '0;
  bit          prev_start = 0;
  bit          prev_ov = 0;
  int          n_starts = 0;
  int          n_out = 0;
  int          start_cyc = 0;
  int          rise_cyc = 0;
  int          ov_cyc = 0;
  logic [15:0] last_out = '0;
  logic [15:0] exp_q [$];
  int          rd_idx = 0;

  logic [15:0] acc_mem [0:1023];
  int          n_acc = 0;
  int          acc_cyc = 0;

  function automatic logic [15:0] f(input logic [15:0] x);
    return x * 16'd3 + 16'h0055;
  endfunction

  assign eng_ready = !e_busy && !eng_block;

  // operand acceptance log
  always @(posedge clock) begin
    if (!reset && in_valid && in_ready) begin
      acc_mem[n_acc] = in_data;
      n_acc++;
      acc_cyc = cyc;
    end
  end

  // engine model, start checks and result consumer
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      e_busy = 0;
      exp_q.delete();
      rd_idx = n_acc;
      prev_start = 0;
      prev_ov = 0;
      out_ready = 1'b0;
    end else begin
      if (eng_start) begin
        chk("start_1cyc", prev_start, 0);
        if (!prev_start) begin
          n_starts++;
          start_cyc = cyc;
          if (rd_idx >= n_acc) chk("start_no_op", 1, 0);
          else begin
            chk("eng_x_load", eng_x, acc_mem[rd_idx]);
            rd_idx++;
          end
        end
      end
      prev_start = eng_start;
      if (!e_busy) begin
        if (eng_start) begin
          e_busy = 1;
          e_x = eng_x;
          e_cnt = lat;
        end
      end else begin
        chk("eng_x_hold", eng_x, e_x);
        if (!hang) begin
          e_cnt--;
          if (e_cnt == 0) begin
            eng_r = fixed_en ? fixed_r : f(e_x);
            exp_q.push_back(eng_r);
            e_busy = 0;
            rise_cyc = cyc;
          end
        end
      end
      out_ready = auto_ready ? 1'($urandom_range(0, 1)) : man_ready;
      if (out_valid && !prev_ov) ov_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          last_out = out_data;
          chk("out_data", out_data, exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_op(input logic [15:0] x);
    int n = 0;
    in_valid = 1'b1;
    in_data = x;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (!in_ready) chk("push_wait", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while ((busy || out_valid || exp_q.size() != 0 ||
            rd_idx != n_acc) && n < lim) begin
      step();
      n++;
    end
    chk("drain", busy || out_valid || exp_q.size() != 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit got=1 exp=0");
    $fatal(1, "time limit");
  end

  initial begin
    int s0;
    int o0;
    int a0;
    int n;
    logic [15:0] xc;

    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_x", eng_x, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    step();
    step();
    reset = 1'b0;

    // single job with fixed result
    lat = 20;
    fixed_en = 1;
    fixed_r = 16'h1234;
    push_op(16'h0100);
    wait_drain(300);
    chk("t1_start_lat", start_cyc - acc_cyc, 2);
    chk("t1_out_lat", ov_cyc - rise_cyc, 2);
    chk("t1_result", last_out, 16'h1234);
    chk("t1_starts", n_starts, 1);
    fixed_en = 0;

    // burst into a stalled engine
    eng_block = 1;
    lat = 3;
    a0 = n_acc;
    o0 = n_out;
    s0 = n_starts;
    for (int i = 0; i < 4; i++) push_op(16'h0a00 + 16'(i));
    chk("t2_four_acc", n_acc - a0, 4);
    in_valid = 1'b1;
    in_data = 16'h0a04;
    chk("t2_full", in_ready, 0);
    chk("t2_busy", busy, 1);
    repeat (3) step();
    chk("t2_full_hold", in_ready, 0);
    chk("t2_no_start", n_starts - s0, 0);
    eng_block = 0;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("t2_fifth_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t2_five_acc", n_acc - a0, 5);
    wait_drain(500);
    chk("t2_results", n_out - o0, 5);

    // result slot held: second launch must wait
    auto_ready = 0;
    man_ready = 0;
    lat = 4;
    s0 = n_starts;
    o0 = n_out;
    push_op(16'h0b01);
    push_op(16'h0b02);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    repeat (20) step();
    chk("t3_held_starts", n_starts - s0, 1);
    chk("t3_held_valid", out_valid, 1);
    chk("t3_held_busy", busy, 1);
    man_ready = 1;
    step();
    man_ready = 0;
    n = 0;
    while (n_starts - s0 < 2 && n < 50) begin
      step();
      n++;
    end
    chk("t3_second_start", n_starts - s0, 2);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    repeat (10) step();
    chk("t3_second_held", out_valid, 1);
    auto_ready = 1;
    wait_drain(200);
    chk("t3_results", n_out - o0, 2);

    // hung engine trips watchdog
    hang = 1;
    o0 = n_out;
    xc = 16'h0c33;
    push_op(xc);
    n = 0;
    while (!eng_start && n < 50) begin
      step();
      n++;
    end
    chk("t4_start", eng_start, 1);
    repeat (TMO - 1) step();
    chk("t4_before", timeout, 0);
    repeat (2) step();
    chk("t4_timeout", timeout, 1);
    chk("t4_idle", busy, 0);
    chk("t4_no_out", out_valid, 0);
    chk("t4_eng_x", eng_x, xc);
    repeat (5) step();
    chk("t4_sticky", timeout, 1);
    chk("t4_no_result", n_out - o0, 0);
    hang = 0;
    #2 reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("t4_cleared", timeout, 0);

    // reset while waiting for engine done
    lat = 30;
    o0 = n_out;
    push_op(16'h0d44);
    n = 0;
    while (!eng_start && n < 50) begin
      step();
      n++;
    end
    repeat (6) step();
    chk("t5_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_eng_start", eng_start, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_eng_x", eng_x, 0);
    step();
    step();
    reset = 1'b0;
    lat = 5;
    push_op(16'h0e55);
    wait_drain(200);
    chk("t5_after", n_out - o0, 1);
    chk("t5_value", last_out, f(16'h0e55));

    // push and pop on the same edge
    eng_block = 1;
    lat = 3;
    o0 = n_out;
    a0 = n_acc;
    push_op(16'h0f01);
    eng_block = 0;
    in_valid = 1'b1;
    in_data = 16'h0f02;
    chk("t6_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t6_start", eng_start, 1);
    chk("t6_busy", busy, 1);
    chk("t6_acc", n_acc - a0, 2);
    wait_drain(200);
    chk("t6_results", n_out - o0, 2);
    chk("t6_last", last_out, f(16'h0f02));

    // random traffic
    o0 = n_out;
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(2, 8);
      repeat ($urandom_range(0, 3)) step();
      push_op(16'($urandom));
    end
    wait_drain(3000);
    chk("t7_results", n_out - o0, 40);
    chk("t7_timeout", timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
